// File: rtl/buf_tag_ctrl.sv
// -----------------------------------------------------------------------------
// buf_tag_ctrl
//
// Tag-lookup and fill controller for a 4-entry buffer pool. It sits directly
// upstream of the least-frequently-used replacement finder.
//   - Hit: reports the matching buffer and tells the finder which buffer was
//     referenced (ref_buf_req qualified by ref_strobe).
//   - Miss: pulses new_buf_req to the finder, takes its victim index, runs the
//     fill handshake, records the new tag and reports the victim buffer.
// Only one request is in flight at a time.
//
// Build option:
//   BUF_TAG_CTRL_INV_FIRST_EN  When defined, a miss fills the lowest-index
//                              invalid entry if there is one, and falls back to
//                              buf_num_replc only when all entries are valid.
//                              When undefined, the victim is always
//                              buf_num_replc. new_buf_req pulses on every miss
//                              in both builds.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/req_ready/req_tag
//                   lookup request; req_ready is combinational
//   flush           clears every valid bit; honoured only in IDLE
//   resp_valid/resp_hit/resp_buf
//                   one-cycle result: hit flag and the buffer holding the tag
//   fill_req/fill_tag/fill_buf/fill_ack
//                   fill handshake; request held until fill_ack
//   new_buf_req     one-cycle pulse asking the finder for a victim
//   ref_buf_req     last referenced buffer; holds its value between hits
//   ref_strobe      one-cycle pulse qualifying ref_buf_req
//   buf_num_replc   victim index from the replacement finder
// -----------------------------------------------------------------------------
module buf_tag_ctrl #(
  parameter int TAG_W   = 8,
  parameter int BUF_BIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic               flush,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [BUF_BIT-1:0] resp_buf,
  output logic               fill_req,
  output logic [TAG_W-1:0]   fill_tag,
  output logic [BUF_BIT-1:0] fill_buf,
  input  logic               fill_ack,
  output logic               new_buf_req,
  output logic [BUF_BIT-1:0] ref_buf_req,
  output logic               ref_strobe,
  input  logic [BUF_BIT-1:0] buf_num_replc
);

  localparam int NUM_BUF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_VICTIM,
    S_FILL,
    S_RESP
  } state_t;

  state_t             state;
  logic [TAG_W-1:0]   tag_q [NUM_BUF];
  logic [NUM_BUF-1:0] valid_q;
  logic [TAG_W-1:0]   req_tag_q;

  logic               hit;
  logic [BUF_BIT-1:0] hit_idx;
  logic [BUF_BIT-1:0] victim;

  // Requests are taken only while idle; a flush in the same cycle wins.
  assign req_ready = (state == S_IDLE) && !flush;

  // Compare the latched tag against every valid entry. Scanning from the top
  // down lets the lowest matching index overwrite any higher one, so the
  // lowest index wins if duplicates ever appear.
  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == req_tag_q)) begin
        hit     = 1'b1;
        hit_idx = BUF_BIT'(i);
      end
    end
  end

`ifdef BUF_TAG_CTRL_INV_FIRST_EN
  // Prefer an empty entry over evicting a live one; same top-down scan so the
  // lowest invalid index is chosen.
  always_comb begin
    victim = buf_num_replc;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim = BUF_BIT'(i);
      end
    end
  end
`else
  // The finder's choice is used as-is, even when empty entries exist.
  assign victim = buf_num_replc;
`endif

  // Single sequential block: state, storage and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value of each register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      valid_q     <= '0;
      // NOTE: the tag array is small register storage, not a RAM, so it is
      // reset with everything else; an abandoned fill leaves no stale tag.
      for (int i = 0; i < NUM_BUF; i++) begin
        tag_q[i] <= '0;
      end
      req_tag_q   <= '0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_buf    <= '0;
      fill_req    <= 1'b0;
      fill_tag    <= '0;
      fill_buf    <= '0;
      new_buf_req <= 1'b0;
      ref_buf_req <= '0;
      ref_strobe  <= 1'b0;
    end else begin
      // One-cycle pulses fall back to zero unless re-asserted below.
      resp_valid  <= 1'b0;
      ref_strobe  <= 1'b0;
      new_buf_req <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid) begin
            req_tag_q <= req_tag;
            state     <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (hit) begin
            resp_valid  <= 1'b1;
            resp_hit    <= 1'b1;
            resp_buf    <= hit_idx;
            ref_strobe  <= 1'b1;
            ref_buf_req <= hit_idx;
            state       <= S_RESP;
          end else begin
            new_buf_req <= 1'b1;
            state       <= S_VICTIM;
          end
        end

        // The finder answers while new_buf_req is high; its index is
        // captured at the end of this cycle. fill_buf doubles as the victim
        // register for the rest of the miss.
        S_VICTIM: begin
          fill_buf <= victim;
          fill_tag <= req_tag_q;
          fill_req <= 1'b1;
          state    <= S_FILL;
        end

        S_FILL: begin
          if (fill_ack) begin
            fill_req          <= 1'b0;
            tag_q[fill_buf]   <= fill_tag;
            valid_q[fill_buf] <= 1'b1;
            resp_valid        <= 1'b1;
            resp_hit          <= 1'b0;
            resp_buf          <= fill_buf;
            state             <= S_RESP;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buf_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buf_tag_ctrl
//
// Self-checking bench for buf_tag_ctrl. A table of lookup transactions
// {tag, finder index, ack delay, flush-while-busy, expected hit, expected
// buffer} is applied in a loop, each transaction checked cycle by cycle.
// Hand-written sequences cover cold miss, reset during FILL and flush racing
// a request. Expected buffers that depend on BUF_TAG_CTRL_INV_FIRST_EN are
// selected with the same macro.
// -----------------------------------------------------------------------------
module tb_buf_tag_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_tag;
  logic       flush;
  logic       resp_valid;
  logic       resp_hit;
  logic [1:0] resp_buf;
  logic       fill_req;
  logic [7:0] fill_tag;
  logic [1:0] fill_buf;
  logic       fill_ack;
  logic       new_buf_req;
  logic [1:0] ref_buf_req;
  logic       ref_strobe;
  logic [1:0] buf_num_replc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] last_ref;

`ifdef BUF_TAG_CTRL_INV_FIRST_EN
  localparam logic [1:0] COLD_BUF  = 2'd0;
  localparam logic [1:0] FLUSH_BUF = 2'd0;
`else
  localparam logic [1:0] COLD_BUF  = 2'd2;
  localparam logic [1:0] FLUSH_BUF = 2'd3;
`endif

  buf_tag_ctrl #(.TAG_W(8), .BUF_BIT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tag      (req_tag),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_buf     (resp_buf),
    .fill_req     (fill_req),
    .fill_tag     (fill_tag),
    .fill_buf     (fill_buf),
    .fill_ack     (fill_ack),
    .new_buf_req  (new_buf_req),
    .ref_buf_req  (ref_buf_req),
    .ref_strobe   (ref_strobe),
    .buf_num_replc(buf_num_replc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tag;
    logic [1:0] replc;
    int         delay;
    logic       flush_mid;
    logic       exp_hit;
    logic [1:0] exp_buf;
  } vec_t;

  localparam int N_VEC = 15;
  vec_t tbl [N_VEC];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, " req_ready"},   req_ready,   1);
    check({pfx, " resp_valid"},  resp_valid,  0);
    check({pfx, " resp_hit"},    resp_hit,    0);
    check({pfx, " resp_buf"},    resp_buf,    0);
    check({pfx, " fill_req"},    fill_req,    0);
    check({pfx, " fill_tag"},    fill_tag,    0);
    check({pfx, " fill_buf"},    fill_buf,    0);
    check({pfx, " new_buf_req"}, new_buf_req, 0);
    check({pfx, " ref_buf_req"}, ref_buf_req, 0);
    check({pfx, " ref_strobe"},  ref_strobe,  0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    tick();
    rst_n    = 1'b1;
    last_ref = 2'd0;
  endtask

  // One full transaction, starting in IDLE, #1 after an edge (cycle 0 setup).
  task automatic do_req(input string nm, input logic [7:0] tag,
                        input logic [1:0] replc, input int delay,
                        input logic flush_mid, input logic exp_hit,
                        input logic [1:0] exp_buf);
    req_valid     = 1'b1;
    req_tag       = tag;
    buf_num_replc = replc;
    #1;
    check({nm, " c0 req_ready"}, req_ready, 1);
    tick();                                   // cycle 1: LOOKUP
    req_valid = 1'b0;
    req_tag   = ~tag;                         // must be ignored
    fill_ack  = 1'b1;                         // ignored outside FILL
    flush     = flush_mid;                    // ignored outside IDLE
    #1;
    check({nm, " c1 req_ready"},  req_ready,   0);
    check({nm, " c1 resp_valid"}, resp_valid,  0);
    tick();                                   // cycle 2
    flush = 1'b0;
    if (exp_hit) begin
      fill_ack = 1'b0;
      check({nm, " hit resp_valid"},  resp_valid,  1);
      check({nm, " hit resp_hit"},    resp_hit,    1);
      check({nm, " hit resp_buf"},    resp_buf,    exp_buf);
      check({nm, " hit ref_strobe"},  ref_strobe,  1);
      check({nm, " hit ref_buf_req"}, ref_buf_req, exp_buf);
      check({nm, " hit new_buf_req"}, new_buf_req, 0);
      check({nm, " hit req_ready"},   req_ready,   0);
      last_ref = exp_buf;
    end else begin
      check({nm, " c2 new_buf_req"}, new_buf_req, 1);
      check({nm, " c2 resp_valid"},  resp_valid,  0);
      check({nm, " c2 fill_req"},    fill_req,    0);
      tick();                                 // cycle 3: FILL
      check({nm, " c3 fill_req"},    fill_req,    1);
      check({nm, " c3 fill_tag"},    fill_tag,    tag);
      check({nm, " c3 fill_buf"},    fill_buf,    exp_buf);
      check({nm, " c3 new_buf_req"}, new_buf_req, 0);
      for (int i = 0; i < delay; i++) begin
        fill_ack = 1'b0;
        tick();
        check({nm, " wait fill_req"}, fill_req,   1);
        check({nm, " wait fill_tag"}, fill_tag,   tag);
        check({nm, " wait fill_buf"}, fill_buf,   exp_buf);
        check({nm, " wait resp"},     resp_valid, 0);
      end
      fill_ack = 1'b1;
      tick();                                 // cycle 4+delay: RESP
      fill_ack = 1'b0;
      check({nm, " miss resp_valid"},  resp_valid,  1);
      check({nm, " miss resp_hit"},    resp_hit,    0);
      check({nm, " miss resp_buf"},    resp_buf,    exp_buf);
      check({nm, " miss fill_req"},    fill_req,    0);
      check({nm, " miss ref_strobe"},  ref_strobe,  0);
      check({nm, " miss ref_buf_req"}, ref_buf_req, last_ref);
    end
    tick();                                   // back in IDLE
    check({nm, " end req_ready"},  req_ready,  1);
    check({nm, " end resp_valid"}, resp_valid, 0);
    check({nm, " end ref_strobe"}, ref_strobe, 0);
  endtask

  initial begin
    // tag, replc, delay, flush_mid, exp_hit, exp_buf
    tbl[0]  = '{8'h00, 2'd0, 0, 1'b0, 1'b0, 2'd0};  // reset tag value still misses
    tbl[1]  = '{8'h3C, 2'd1, 0, 1'b0, 1'b0, 2'd1};
    tbl[2]  = '{8'h3C, 2'd3, 0, 1'b0, 1'b1, 2'd1};
    tbl[3]  = '{8'hFF, 2'd2, 0, 1'b0, 1'b0, 2'd2};
    tbl[4]  = '{8'h66, 2'd3, 5, 1'b0, 1'b0, 2'd3};  // ack delayed 5 cycles
    tbl[5]  = '{8'h00, 2'd1, 0, 1'b1, 1'b1, 2'd0};  // flush while busy ignored
    tbl[6]  = '{8'hFF, 2'd0, 0, 1'b0, 1'b1, 2'd2};
    tbl[7]  = '{8'h66, 2'd0, 0, 1'b0, 1'b1, 2'd3};
    tbl[8]  = '{8'h77, 2'd3, 0, 1'b0, 1'b0, 2'd3};  // full pool: finder's pick
    tbl[9]  = '{8'h77, 2'd0, 0, 1'b0, 1'b1, 2'd3};
    tbl[10] = '{8'h66, 2'd1, 2, 1'b0, 1'b0, 2'd1};  // evicted tag misses
    tbl[11] = '{8'h3C, 2'd0, 0, 1'b0, 1'b0, 2'd0};
    tbl[12] = '{8'h66, 2'd2, 0, 1'b0, 1'b1, 2'd1};
    tbl[13] = '{8'h00, 2'd2, 0, 1'b0, 1'b0, 2'd2};
    tbl[14] = '{8'hFF, 2'd3, 0, 1'b0, 1'b0, 2'd3};

    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_tag       = 8'h00;
    flush         = 1'b0;
    fill_ack      = 1'b0;
    buf_num_replc = 2'd0;
    last_ref      = 2'd0;
    #2;
    check_reset_values("por");
    tick();
    rst_n = 1'b1;
    tick();

    // Cold miss: config-dependent victim, then a hit on it.
    do_req("cold_miss", 8'h3C, 2'd2, 0, 1'b0, 1'b0, COLD_BUF);
    do_req("cold_hit",  8'h3C, 2'd1, 0, 1'b0, 1'b1, COLD_BUF);

    // Table section: fills in index order, identical for both builds.
    do_reset();
    for (int v = 0; v < N_VEC; v++) begin
      do_req($sformatf("vec%0d", v), tbl[v].tag, tbl[v].replc, tbl[v].delay,
             tbl[v].flush_mid, tbl[v].exp_hit, tbl[v].exp_buf);
    end

    // Reset during FILL abandons the fill and forgets all tags.
    req_valid     = 1'b1;
    req_tag       = 8'h99;
    buf_num_replc = 2'd2;
    tick();
    req_valid = 1'b0;
    tick();
    check("rstfill new_buf_req", new_buf_req, 1);
    tick();
    check("rstfill fill_req before", fill_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstfill fill_req", fill_req, 0);
    check("rstfill req_ready", req_ready, 1);
    check_reset_values("rstfill");
    tick();
    rst_n    = 1'b1;
    last_ref = 2'd0;
    tick();
    check("rstfill no resp", resp_valid, 0);
    do_req("after_rst", 8'hFF, 2'd0, 0, 1'b0, 1'b0, 2'd0);

    // flush racing a request: request refused, valid bits cleared.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_tag   = 8'hFF;
    #1;
    check("flush req_ready", req_ready, 0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush not accepted", req_ready, 1);
    check("flush no new_buf", new_buf_req, 0);
    tick();
    check("flush still idle", req_ready, 1);
    check("flush no resp", resp_valid, 0);
    do_req("post_flush", 8'hFF, 2'd3, 0, 1'b0, 1'b0, FLUSH_BUF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buf_tag_ctrl.md
# buf_tag_ctrl

- Tag-lookup and fill controller for the 4-entry buffer pool.
- Sits directly upstream of the least-frequently-used replacement finder:
  - on a hit, it drives the finder's reference index;
  - on a miss, it pulses the finder's new-buffer request and consumes its replacement index as the victim.
- It then sequences the fill handshake, records the new tag, and returns the hit/miss result with the buffer number to the requester.

## Interface
- TAG_W, 8, tag width in bits
- BUF_BIT, 2, buffer index width; entry count is fixed at 4
- Reset rst_n is asynchronous, active-low; clock is clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  lookup request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_tag  in  TAG_W  tag to look up
- flush  in  1  clear all entry valid bits (honoured in IDLE only)
- resp_valid  out  1  one-cycle result pulse
- resp_hit  out  1  1 = hit, 0 = miss then fill
- resp_buf  out  BUF_BIT  buffer holding the tag
- fill_req  out  1  fill request, held until acknowledged
- fill_tag  out  TAG_W  tag being filled
- fill_buf  out  BUF_BIT  destination buffer of the fill
- fill_ack  in  1  fill done; sampled only in FILL
- new_buf_req  out  1  one-cycle pulse to the replacement finder
- ref_buf_req  out  BUF_BIT  referenced buffer index to the finder; holds its last value between hits
- ref_strobe  out  1  one-cycle pulse qualifying ref_buf_req
- buf_num_replc  in  BUF_BIT  victim index from the replacement finder

## Operation
- Storage per entry: tag register (TAG_W bits) and valid bit.
- FSM states and transitions:
  - IDLE: go to LOOKUP on acceptance.
  - LOOKUP: go to RESP on a hit, to VICTIM on a miss.
  - VICTIM: always go to FILL.
  - FILL: stay until fill_ack, then go to RESP.
  - RESP: always go to IDLE.
- req_ready = (state == IDLE) && !flush; this is combinational.
- On acceptance, req_tag is latched. External changes to req_tag after acceptance are ignored.
- flush in IDLE clears all valid bits at the edge; flush wins over a simultaneous req_valid.
- LOOKUP compares the latched tag against all valid entries.
  - A hit selects the matching index.
  - Duplicate tags cannot arise; if more than one entry matches anyway, the lowest index wins.
- Hit path, in RESP:
  - resp_valid=1, resp_hit=1, resp_buf=index;
  - ref_strobe=1, with ref_buf_req updated to index.
- Miss path, in VICTIM:
  - new_buf_req=1 for exactly that cycle;
  - the victim is latched at the end of VICTIM.
- FILL:
  - fill_req=1, with fill_tag/fill_buf stable, until fill_ack is sampled high.
  - At that edge, tag[victim] is written and valid[victim] is set.
- Miss path, in RESP: resp_valid=1, resp_hit=0, resp_buf=victim. No ref_strobe on a miss.
- fill_ack outside FILL is ignored. flush outside IDLE is ignored and is not remembered.
- Reset mid-operation returns to IDLE and clears all valid bits and tags. An in-flight fill is abandoned with no response.

## Timing
- Cycle 0 is the acceptance edge.
- Hit: resp_valid in cycle 2 (latency 2). req_ready returns high in cycle 3.
- Miss: new_buf_req in cycle 2; fill_req from cycle 3.
  - If fill_ack is high in cycle 3+k, resp_valid is in cycle 4+k.
  - Minimum miss latency is 4.
- Throughput: at most one outstanding request; req_ready stays low from cycle 1 through RESP.
- All outputs are registered except req_ready.
- Reset values:
  - req_ready=1;
  - resp_valid=0, resp_hit=0, resp_buf=0;
  - fill_req=0, fill_tag=0, fill_buf=0;
  - new_buf_req=0, ref_buf_req=0, ref_strobe=0.

## Configuration
- BUF_TAG_CTRL_INV_FIRST_EN defined:
  - the victim is the lowest-index invalid entry if one exists, otherwise buf_num_replc;
  - new_buf_req is still pulsed for every miss.
- Undefined: the victim is always buf_num_replc sampled in VICTIM, even if invalid entries exist.

## Test plan
- Cold miss after reset, tag 0x3C, buf_num_replc=2, fill_ack in cycle 3:
  - macro undefined → new_buf_req in cycle 2, fill_buf=2, resp_hit=0, resp_buf=2 in cycle 4;
  - with the macro → fill_buf=0.
- Fill tag 0x3C into buffer 1, then request 0x3C:
  - resp_valid cycle 2, resp_hit=1, resp_buf=1;
  - ref_strobe=1, ref_buf_req=1;
  - new_buf_req stays 0.
- Fill all 4 entries, then miss on 0x77 with buf_num_replc=3 (either config):
  - fill_buf=3, tag[3]=0x77;
  - a following lookup of the old tag[3] misses.
- Miss with fill_ack delayed 5 cycles:
  - fill_req, fill_tag, fill_buf stay stable for 6 cycles;
  - resp_valid exactly one cycle after the ack.
- rst_n low during FILL:
  - immediately fill_req=0, req_ready=1;
  - a subsequent lookup of the previously filled tag misses.
- flush in IDLE together with req_valid:
  - req_ready=0 and the request is not accepted;
  - next cycle it is accepted, and a previously valid tag misses.
